// File: rtl/dmem_access_pkg.sv
// Shared types for the data-memory access unit: access sizes, FSM states,
// the default IO select bit and the alignment rule.
package dmem_access_pkg;

  localparam int unsigned IO_BIT_DEFAULT = 31;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'd0,
    SZ_HALF     = 2'd1,
    SZ_WORD     = 2'd2,
    SZ_WORD_ALT = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_DATA,
    ST_MERGE,
    ST_WR,
    ST_MISALIGN
  } state_e;

  // Encoding 3 behaves as a word, so anything that is not byte/half needs a word boundary.
  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lane);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane handling: extracts/extends load data from a word
// and merges a byte/half store into an old word (little-endian lanes).
module dmem_lane_fmt
  import dmem_access_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] load_value,
  output logic [31:0] merged_word
);

  logic [31:0] shifted;

  always_comb begin
    shifted     = old_word >> {lane, 3'b000};
    load_value  = old_word;
    merged_word = old_word;
    case (size)
      SZ_BYTE: begin
        load_value = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        case (lane)
          2'd0:    merged_word[7:0]   = new_data[7:0];
          2'd1:    merged_word[15:8]  = new_data[7:0];
          2'd2:    merged_word[23:16] = new_data[7:0];
          default: merged_word[31:24] = new_data[7:0];
        endcase
      end
      SZ_HALF: begin
        load_value = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        if (lane[1]) begin
          merged_word[31:16] = new_data[15:0];
        end else begin
          merged_word[15:0] = new_data[15:0];
        end
      end
      default: begin
        load_value  = old_word;
        merged_word = new_data;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store controller between the MEM stage and a word-wide DMEM with one
// cycle read latency; does RMW for sub-word RAM stores and load formatting.
module dmem_access_unit
  import dmem_access_pkg::*;
#(
  parameter int unsigned IO_BIT = IO_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        dmem_we,
  output logic [31:0] dmem_ask_addr,
  output logic [31:0] dmem_fetch_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  state_e      state_q, state_d;
  size_e       size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        sign_q, sign_d;
  logic        store_q, store_d;
  logic [31:0] data_q, data_d;
  logic [31:0] old_q, old_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ask_q, ask_d;

  size_e       req_size;
  logic        req_word;
  logic        req_io;
  logic [31:0] fmt_old;
  logic [31:0] fmt_load;
  logic [31:0] fmt_merged;

  assign req_size = size_e'(size);
  assign req_word = size[1];
  assign req_io   = addr[IO_BIT];

  // Loads format live read data; the merge step works from the captured old word.
  assign fmt_old = (state_q == ST_MERGE) ? old_q : dmem_rdata;

  dmem_lane_fmt u_lane_fmt (
    .size       (size_q),
    .lane       (lane_q),
    .sign_ext   (sign_q),
    .old_word   (fmt_old),
    .new_data   (data_q),
    .load_value (fmt_load),
    .merged_word(fmt_merged)
  );

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    lane_d  = lane_q;
    sign_d  = sign_q;
    store_d = store_q;
    data_d  = data_q;
    old_d   = old_q;
    wdata_d = wdata_q;
    ask_d   = ask_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          size_d  = req_size;
          lane_d  = addr[1:0];
          sign_d  = sign_ext;
          store_d = is_store;
          data_d  = store_data;
          if (is_misaligned(req_size, addr[1:0])) begin
            state_d = ST_MISALIGN;
          end else begin
            ask_d   = {addr[31:2], 2'b00};
            wdata_d = store_data;
            state_d = (is_store && (req_word || req_io)) ? ST_WR : ST_RD;
          end
        end
      end
      ST_RD: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (store_q) begin
          old_d   = dmem_rdata;
          state_d = ST_MERGE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MERGE: begin
        wdata_d = fmt_merged;
        state_d = ST_WR;
      end
      ST_WR:       state_d = ST_IDLE;
      ST_MISALIGN: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      size_q  <= SZ_BYTE;
      lane_q  <= 2'b00;
      sign_q  <= 1'b0;
      store_q <= 1'b0;
      data_q  <= '0;
      old_q   <= '0;
      wdata_q <= '0;
      ask_q   <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      sign_q  <= sign_d;
      store_q <= store_d;
      data_q  <= data_d;
      old_q   <= old_d;
      wdata_q <= wdata_d;
      ask_q   <= ask_d;
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign misalign        = (state_q == ST_MISALIGN);
  assign dmem_we         = (state_q == ST_WR);
  assign done            = (state_q == ST_WR) || (state_q == ST_MISALIGN) ||
                           ((state_q == ST_RD_DATA) && !store_q);
  assign load_data       = ((state_q == ST_RD_DATA) && !store_q) ? fmt_load : '0;
  assign dmem_ask_addr   = ask_q;
  assign dmem_fetch_addr = ask_q;
  assign dmem_wdata      = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a small word memory model behind
// the DMEM port; expected values are hand-computed per access.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, misalign, dmem_we;
  logic [31:0] load_data, dmem_ask_addr, dmem_fetch_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;

  int checkCount = 0;
  int passCount  = 0;
  int weCount    = 0;
  int startWe;

  logic [31:0] mem [logic [29:0]];
  logic [31:0] memRead;

  always #5 clk = ~clk;

  dmem_access_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .is_store       (is_store),
    .size           (size),
    .sign_ext       (sign_ext),
    .addr           (addr),
    .store_data     (store_data),
    .busy           (busy),
    .done           (done),
    .load_data      (load_data),
    .misalign       (misalign),
    .dmem_we        (dmem_we),
    .dmem_ask_addr  (dmem_ask_addr),
    .dmem_fetch_addr(dmem_fetch_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata)
  );

  // Word memory with one-cycle registered read; writes land on the edge ending the we cycle.
  always @(posedge clk) begin
    memRead = mem.exists(dmem_fetch_addr[31:2]) ? mem[dmem_fetch_addr[31:2]] : 32'h0;
    if (dmem_we) begin
      mem[dmem_ask_addr[31:2]] = dmem_wdata;
      weCount++;
    end
    dmem_rdata <= memRead;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic st, input logic [1:0] sz,
                               input logic sx, input logic [31:0] a, input logic [31:0] d,
                               input int expLat, input logic expMis, input logic [31:0] expData,
                               input int expWrites);
    int cycles;
    @(negedge clk);
    req = 1'b1; is_store = st; size = sz; sign_ext = sx; addr = a; store_data = d;
    startWe = weCount;
    @(posedge clk);
    #1;
    req = 1'b0; is_store = ~st; size = ~sz; sign_ext = ~sx;
    addr = 32'hFFFF_FFFF; store_data = 32'hDEAD_BEEF;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 8);
    checkOutput({tag, ".lat"}, cycles, expLat);
    checkOutput({tag, ".mis"}, {31'b0, misalign}, {31'b0, expMis});
    checkOutput({tag, ".we"}, {31'b0, dmem_we}, {31'b0, st & ~expMis});
    if (!expMis) begin
      checkOutput({tag, ".ask"}, dmem_ask_addr, {a[31:2], 2'b00});
      checkOutput({tag, ".fetch"}, dmem_fetch_addr, {a[31:2], 2'b00});
      if (st) checkOutput({tag, ".wdata"}, dmem_wdata, expData);
      else    checkOutput({tag, ".load"}, load_data, expData);
    end
    @(negedge clk);
    checkOutput({tag, ".idle"}, {30'b0, busy, done}, 32'h0);
    checkOutput({tag, ".writes"}, weCount - startWe, expWrites);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    mem[30'h2000_0001] = 32'h0000_003C;
    #12;
    checkOutput("reset.busy", {31'b0, busy}, 32'h0);
    checkOutput("reset.done", {31'b0, done}, 32'h0);
    checkOutput("reset.we", {31'b0, dmem_we}, 32'h0);
    checkOutput("reset.ask", dmem_ask_addr, 32'h0);
    checkOutput("reset.wdata", dmem_wdata, 32'h0);
    checkOutput("reset.load", load_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //            tag      st    sz     sx    addr          data          lat mis   expected       wr
    applyStimulus("sw",    1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h1122_3344, 1, 1'b0, 32'h1122_3344, 1);
    applyStimulus("lw",    1'b0, 2'd2, 1'b1, 32'h0000_0100, 32'h0,        2, 1'b0, 32'h1122_3344, 0);
    applyStimulus("sb",    1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_00A5, 4, 1'b0, 32'h1122_A544, 1);
    applyStimulus("lb",    1'b0, 2'd0, 1'b1, 32'h0000_0101, 32'h0,        2, 1'b0, 32'hFFFF_FFA5, 0);
    applyStimulus("lbu",   1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,        2, 1'b0, 32'h0000_00A5, 0);
    applyStimulus("lh_hi", 1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0,        2, 1'b0, 32'h0000_1122, 0);
    applyStimulus("lh_lo", 1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'h0,        2, 1'b0, 32'hFFFF_A544, 0);
    applyStimulus("sh",    1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h5555_BEEF, 4, 1'b0, 32'hBEEF_A544, 1);
    applyStimulus("lw2",   1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,        2, 1'b0, 32'hBEEF_A544, 0);
    applyStimulus("io_lw", 1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0,        2, 1'b0, 32'h0000_003C, 0);
    applyStimulus("io_sb", 1'b1, 2'd0, 1'b0, 32'h8000_0008, 32'h0000_1234, 1, 1'b0, 32'h0000_1234, 1);
    applyStimulus("mis_lw",1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,        1, 1'b1, 32'h0,        0);
    applyStimulus("mis_sh",1'b1, 2'd1, 1'b0, 32'h0000_0103, 32'h0000_7777, 1, 1'b1, 32'h0,        0);

    // Abort a byte store while it sits in the merge cycle.
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; size = 2'd0; sign_ext = 1'b0;
    addr = 32'h0000_0100; store_data = 32'h0000_005A;
    startWe = weCount;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.pre_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst.we", {31'b0, dmem_we}, 32'h0);
    checkOutput("rst.busy", {31'b0, busy}, 32'h0);
    checkOutput("rst.done", {31'b0, done}, 32'h0);
    checkOutput("rst.ask", dmem_ask_addr, 32'h0);
    checkOutput("rst.wdata", dmem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst.writes", weCount - startWe, 32'h0);
    applyStimulus("lw_post", 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 2, 1'b0, 32'hBEEF_A544, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
